mem_lsu: RTL and testbench

Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB register. Non-memory instructions pass through unchanged to the MEM/WB inputs (`mem_wd`, `mem_wdata`, `mem_wreg`, `mem_hi`, `mem_lo`, `mem_whilo`). Loads and stores run a request/acknowledge transaction on the data bus. While a transaction is outstanding, the stage raises `stallreq` to the pause controller.

---
 rtl/mem_lsu.sv | 209 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-access stage: pass-through for ALU ops, req/ack bus transaction for loads/stores.
// Optional alignment exceptions (mem_adel/mem_ades) enabled by UNALIGNED_EXC_EN.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        stallreq
`ifdef UNALIGNED_EXC_EN
    ,
    output logic        mem_adel,
    output logic        mem_ades
`endif
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, is_mem, sgn, misal;
    logic [1:0]  sz;
    logic [3:0]  sel;
    logic [31:0] wdat, ld;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    logic        req, stall, wreg, whilo, adel, ades;
    logic [4:0]  wd;
    logic [31:0] wdata;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz       = SZ_W;
        sgn      = 1'b0;
        unique case (ex_aluop)
            EXE_LB_OP:  begin is_load = 1'b1; sz = SZ_B; sgn = 1'b1; end
            EXE_LBU_OP: begin is_load = 1'b1; sz = SZ_B; end
            EXE_LH_OP:  begin is_load = 1'b1; sz = SZ_H; sgn = 1'b1; end
            EXE_LHU_OP: begin is_load = 1'b1; sz = SZ_H; end
            EXE_LW_OP:  begin is_load = 1'b1; sz = SZ_W; end
            EXE_SB_OP:  begin is_store = 1'b1; sz = SZ_B; end
            EXE_SH_OP:  begin is_store = 1'b1; sz = SZ_H; end
            EXE_SW_OP:  begin is_store = 1'b1; sz = SZ_W; end
            default:    ;
        endcase
    end

    assign is_mem = is_load | is_store;

`ifdef UNALIGNED_EXC_EN
    assign misal = is_mem &&
                   (((sz == SZ_H) && ex_mem_addr[0]) ||
                    ((sz == SZ_W) && (ex_mem_addr[1:0] != 2'b00)));
`else
    assign misal = 1'b0;
`endif

    // Lanes are big-endian: offset 0 is the most significant byte.
    always_comb begin
        sel  = 4'b1111;
        wdat = ex_reg2;
        unique case (sz)
            SZ_B: begin
                sel  = 4'b1000 >> ex_mem_addr[1:0];
                wdat = {4{ex_reg2[7:0]}};
            end
            SZ_H: begin
                sel  = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                wdat = {2{ex_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (ex_mem_addr[1:0])
            2'd0:    ld_b = rdata_q[31:24];
            2'd1:    ld_b = rdata_q[23:16];
            2'd2:    ld_b = rdata_q[15:8];
            default: ld_b = rdata_q[7:0];
        endcase
        ld_h = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        unique case (sz)
            SZ_B:    ld = {{24{sgn & ld_b[7]}}, ld_b};
            SZ_H:    ld = {{16{sgn & ld_h[15]}}, ld_h};
            default: ld = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        stall   = 1'b0;
        wd      = ex_wd;
        wreg    = ex_wreg;
        wdata   = ex_wdata;
        whilo   = ex_whilo;
        adel    = 1'b0;
        ades    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem && misal) begin
                    adel  = is_load;
                    ades  = is_store;
                    wreg  = 1'b0;
                    whilo = 1'b0;
                end else if (is_mem) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    wreg  = 1'b0;
                    whilo = 1'b0;
                    if (bus_ack) begin
                        rdata_d = bus_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                wreg  = 1'b0;
                whilo = 1'b0;
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                wreg    = is_load & ex_wreg;
                wdata   = is_load ? ld : ex_wdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs are gated by rst so an abandoned request drops without a clock edge.
    assign bus_req   = rst & req;
    assign bus_we    = rst & req & is_store;
    assign bus_addr  = (rst & req) ? {ex_mem_addr[31:2], 2'b00} : 32'd0;
    assign bus_sel   = (rst & req) ? sel : 4'd0;
    assign bus_wdata = (rst & req & is_store) ? wdat : 32'd0;
    assign stallreq  = rst & stall;
    assign mem_wd    = rst ? wd : 5'd0;
    assign mem_wreg  = rst & wreg;
    assign mem_wdata = rst ? wdata : 32'd0;
    assign mem_hi    = rst ? ex_hi : 32'd0;
    assign mem_lo    = rst ? ex_lo : 32'd0;
    assign mem_whilo = rst & whilo;

`ifdef UNALIGNED_EXC_EN
    assign mem_adel  = rst & adel;
    assign mem_ades  = rst & ades;
`else
    logic unused_exc;
    assign unused_exc = adel | ades;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: transaction-level model plus directed literal checks.
module tb_mem_lsu;

    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_LB   = 8'b1110_0000;
    localparam logic [7:0] OP_LH   = 8'b1110_0001;
    localparam logic [7:0] OP_LW   = 8'b1110_0011;
    localparam logic [7:0] OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] OP_SB   = 8'b1110_1000;
    localparam logic [7:0] OP_SH   = 8'b1110_1001;
    localparam logic [7:0] OP_SW   = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0;
    logic        ex_whilo = 1'b0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_mem_addr = '0, ex_reg2 = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_req, bus_we, mem_wreg, mem_whilo, stallreq;
    logic [31:0] bus_addr, bus_wdata, mem_wdata, mem_hi, mem_lo;
    logic [3:0]  bus_sel;
    logic [4:0]  mem_wd;
`ifdef UNALIGNED_EXC_EN
    logic        mem_adel, mem_ades;
`endif

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .stallreq(stallreq)
`ifdef UNALIGNED_EXC_EN
        , .mem_adel(mem_adel), .mem_ades(mem_ades)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int m_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit m_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic int m_off(input logic [7:0] op, input logic [31:0] a);
        int n = m_size(op);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int n = m_size(op);
        int mask = ((1 << n) - 1) << (4 - m_off(op, a) - n);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_bw(input logic [7:0] op, input logic [31:0] r);
        int n = m_size(op);
        logic [31:0] v = 0;
        for (int i = 0; i < 4 / n; i++)
            v = v | ((r & ((64'd1 << (8 * n)) - 1)) << (8 * n * i));
        return v;
    endfunction

    function automatic logic [31:0] m_ld(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
        int n = m_size(op);
        longint mask = (64'd1 << (8 * n)) - 1;
        longint v = (longint'(rd) >> (8 * (4 - m_off(op, a) - n))) & mask;
        bit sg = (op == OP_LB) || (op == OP_LH);
        if (sg && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- per-cycle expectations ----------------
    bit          e_on = 0, e_req, e_stall, e_we, e_wreg, e_whilo, e_chkw;
    bit          e_adel, e_ades;
    logic [31:0] e_addr, e_bw, e_wdata;
    logic [3:0]  e_sel;
    logic [4:0]  e_wd;

    always @(negedge clk) begin
        if (e_on) begin
            cmp("bus_req", 32'(bus_req), 32'(e_req));
            cmp("stallreq", 32'(stallreq), 32'(e_stall));
            cmp("mem_wd", 32'(mem_wd), 32'(e_wd));
            cmp("mem_wreg", 32'(mem_wreg), 32'(e_wreg));
            cmp("mem_whilo", 32'(mem_whilo), 32'(e_whilo));
            cmp("mem_hi", mem_hi, ex_hi);
            cmp("mem_lo", mem_lo, ex_lo);
            if (e_chkw) cmp("mem_wdata", mem_wdata, e_wdata);
            if (e_req) begin
                cmp("bus_we", 32'(bus_we), 32'(e_we));
                cmp("bus_addr", bus_addr, e_addr);
                cmp("bus_sel", 32'(bus_sel), 32'(e_sel));
                if (e_we) cmp("bus_wdata", bus_wdata, e_bw);
            end
`ifdef UNALIGNED_EXC_EN
            cmp("mem_adel", 32'(mem_adel), 32'(e_adel));
            cmp("mem_ades", 32'(mem_ades), 32'(e_ades));
`endif
        end
    end

    // Values seen during the most recent op, for literal checks.
    int          d_stalls;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_bw, d_wdata;
    logic        d_we, d_wreg;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [7:0] op, input logic [4:0] wd, input logic wr,
                          input logic [31:0] a, input logic [31:0] r2, input logic [31:0] wdat);
        ex_aluop = op; ex_wd = wd; ex_wreg = wr; ex_mem_addr = a;
        ex_reg2 = r2; ex_wdata = wdat;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'b0;
        e_adel = 0; e_ades = 0;
    endtask

    task automatic run_alu(input logic [4:0] wd, input logic [31:0] wdat, input logic ack);
        set_ex(OP_ADDU, wd, 1'b1, 32'h0, 32'h0, wdat);
        ex_whilo = 1'b1;
        bus_ack = ack;
        e_on = 1; e_req = 0; e_stall = 0; e_wd = wd; e_wreg = 1; e_whilo = 1;
        e_chkw = 1; e_wdata = wdat;
        @(negedge clk);
        d_wdata = mem_wdata; d_wreg = mem_wreg;
        next_cycle();
        bus_ack = 1'b0;
    endtask

    task automatic run_mem(input logic [7:0] op, input logic [4:0] wd, input logic [31:0] a,
                           input logic [31:0] r2, input logic [31:0] rd, input int waits,
                           input logic ack_done);
        bit ld = m_load(op);
        set_ex(op, wd, 1'b1, a, r2, 32'hC0DE_0000 | a);
        d_stalls = 0;
        e_on = 1; e_req = 1; e_stall = 1; e_we = !ld; e_addr = a & ~32'd3;
        e_sel = m_sel(op, a); e_bw = m_bw(op, r2); e_wd = wd; e_wreg = 0;
        e_whilo = 0; e_chkw = 0;
        for (int k = 0; k <= waits; k++) begin
            bus_ack = (k == waits);
            bus_rdata = (k == waits) ? rd : ~rd;
            @(negedge clk);
            d_stalls += int'(stallreq);
            if (k == 0) begin
                d_sel = bus_sel; d_addr = bus_addr; d_bw = bus_wdata; d_we = bus_we;
            end
            next_cycle();
        end
        bus_ack = ack_done;
        bus_rdata = 32'h5A5A_5A5A;
        e_req = 0; e_stall = 0; e_wreg = ld; e_chkw = 1;
        e_wdata = ld ? m_ld(op, a, rd) : ex_wdata;
        @(negedge clk);
        d_stalls += int'(stallreq);
        d_wdata = mem_wdata; d_wreg = mem_wreg;
        next_cycle();
        bus_ack = 1'b0;
    endtask

    initial begin
        // Reset held: outputs all zero despite active inputs.
        set_ex(OP_LW, 5'd7, 1'b1, 32'h40, 32'h1, 32'h99);
        bus_ack = 1'b1;
        @(negedge clk);
        cmp("rst bus_req", 32'(bus_req), 32'd0);
        cmp("rst stallreq", 32'(stallreq), 32'd0);
        cmp("rst mem_wdata", mem_wdata, 32'd0);
        cmp("rst mem_wreg", 32'(mem_wreg), 32'd0);
        cmp("rst mem_hi", mem_hi, 32'd0);
        next_cycle();
        rst = 1'b1;
        bus_ack = 1'b0;

        run_alu(5'd5, 32'h1234, 1'b0);
        cmp("addu wdata", d_wdata, 32'h1234);
        cmp("addu wreg", 32'(d_wreg), 32'd1);

        run_mem(OP_LB, 5'd3, 32'h101, 32'h0, 32'h11A2_3344, 2, 1'b0);
        cmp("lb stalls", d_stalls, 3);
        cmp("lb sel", 32'(d_sel), 32'h4);
        cmp("lb wdata", d_wdata, 32'hFFFF_FFA2);
        run_mem(OP_LBU, 5'd3, 32'h101, 32'h0, 32'h11A2_3344, 0, 1'b0);
        cmp("lbu wdata", d_wdata, 32'h0000_00A2);

        run_mem(OP_SH, 5'd0, 32'h202, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        cmp("sh we", 32'(d_we), 32'd1);
        cmp("sh sel", 32'(d_sel), 32'h3);
        cmp("sh bwdata", d_bw, 32'hBEEF_BEEF);
        cmp("sh addr", d_addr, 32'h200);
        cmp("sh wreg", 32'(d_wreg), 32'd0);
        cmp("sh stalls", d_stalls, 1);

        run_mem(OP_LW, 5'd8, 32'h300, 32'h0, 32'hAAAA_0001, 1, 1'b0);
        cmp("lw0 wdata", d_wdata, 32'hAAAA_0001);
        run_mem(OP_LW, 5'd9, 32'h304, 32'h0, 32'hBBBB_0002, 0, 1'b0);
        cmp("lw1 addr", d_addr, 32'h304);
        cmp("lw1 wdata", d_wdata, 32'hBBBB_0002);

        // Ack during DONE and during a non-memory op must be ignored.
        run_mem(OP_LH, 5'd10, 32'h102, 32'h0, 32'h1234_8765, 1, 1'b1);
        cmp("lh wdata", d_wdata, 32'hFFFF_8765);
        run_mem(OP_LHU, 5'd11, 32'h100, 32'h0, 32'h8765_1234, 0, 1'b1);
        cmp("lhu wdata", d_wdata, 32'h0000_8765);
        run_alu(5'd12, 32'h55, 1'b1);
        run_mem(OP_SB, 5'd0, 32'h003, 32'h0000_00C3, 32'h0, 3, 1'b0);
        cmp("sb sel", 32'(d_sel), 32'h1);
        cmp("sb bwdata", d_bw, 32'hC3C3_C3C3);
        run_mem(OP_SW, 5'd0, 32'h010, 32'h0BAD_F00D, 32'h0, 0, 1'b0);
        cmp("sw bwdata", d_bw, 32'h0BAD_F00D);

        // Reset asserted mid-transaction.
        run_alu(5'd1, 32'h1, 1'b0);
        set_ex(OP_LW, 5'd4, 1'b1, 32'h500, 32'h0, 32'h0);
        e_on = 0;
        next_cycle();
        cmp("req before rst", 32'(bus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        cmp("rst req drop", 32'(bus_req), 32'd0);
        cmp("rst stall drop", 32'(stallreq), 32'd0);
        next_cycle();
        rst = 1'b1;
        run_alu(5'd2, 32'h77, 1'b1);
        run_alu(5'd2, 32'h78, 1'b0);
        cmp("post-rst idle", d_wdata, 32'h78);

`ifdef UNALIGNED_EXC_EN
        set_ex(OP_LW, 5'd6, 1'b1, 32'h102, 32'h0, 32'h0);
        e_on = 1; e_req = 0; e_stall = 0; e_wd = 5'd6; e_wreg = 0; e_whilo = 0;
        e_chkw = 0; e_adel = 1; e_ades = 0;
        @(negedge clk);
        cmp("lw misal adel", 32'(mem_adel), 32'd1);
        cmp("lw misal req", 32'(bus_req), 32'd0);
        next_cycle();
        set_ex(OP_SH, 5'd0, 1'b0, 32'h201, 32'h0, 32'h0);
        e_adel = 0; e_ades = 1;
        @(negedge clk);
        cmp("sh misal ades", 32'(mem_ades), 32'd1);
        next_cycle();
        run_alu(5'd3, 32'h3, 1'b0);
`else
        run_mem(OP_LW, 5'd6, 32'h102, 32'h0, 32'hFACE_CAFE, 0, 1'b0);
        cmp("lw force addr", d_addr, 32'h100);
        cmp("lw force sel", 32'(d_sel), 32'hF);
        cmp("lw force wdata", d_wdata, 32'hFACE_CAFE);
`endif

        e_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
